// File: rtl/vga_text_renderer_if.sv
// Scanner, text RAM, font ROM and cursor-register signals of the text renderer.
// slave is the renderer side; master is the surrounding scanner/memory/CPU side.
interface vga_text_renderer_if;
  logic [9:0]  HAddr;
  logic [8:0]  VAddr;
  logic        frameStart;
  logic [11:0] charAddr;
  logic [15:0] charData;
  logic [11:0] fontAddr;
  logic [7:0]  fontData;
  logic        cursorWe;
  logic [12:0] cursorDin;
  logic [12:0] cursorReg;
  logic [11:0] videoIn;

  modport master (
    output HAddr, VAddr, frameStart, charData, fontData, cursorWe, cursorDin,
    input  charAddr, fontAddr, cursorReg, videoIn
  );

  modport slave (
    input  HAddr, VAddr, frameStart, charData, fontData, cursorWe, cursorDin,
    output charAddr, fontAddr, cursorReg, videoIn
  );
endinterface

// File: rtl/vga_text_renderer.sv
// 80x30 text-mode pixel source with blinking cursor; pixel out 2 cycles after its coordinate.
// Fixed one-pixel-per-cycle pipeline, no stalls and no backpressure.
module vga_text_renderer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input logic                 clk,
  input logic                 rst_n,
  vga_text_renderer_if.slave  bus
);
  localparam logic [9:0] H_ACTIVE = 10'(COLS * 8);
  localparam logic [8:0] V_ACTIVE = 9'(ROWS * 16);
  localparam int         BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [6:0]    col;
  logic [4:0]    row;
  logic          in_range0, hit0;
  logic [2:0]    xbit1, xbit2;
  logic [3:0]    grow1;
  logic          in_range1, hit1, in_range2, hit2;
  logic [3:0]    fg2, bg2;
  logic [12:0]   cursor_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic          pix_bit;

  function automatic logic [11:0] pal(input logic [3:0] idx);
    case (idx)
      4'h0: pal = 12'h000;  4'h1: pal = 12'h00A;  4'h2: pal = 12'h0A0;  4'h3: pal = 12'h0AA;
      4'h4: pal = 12'hA00;  4'h5: pal = 12'hA0A;  4'h6: pal = 12'hA50;  4'h7: pal = 12'hAAA;
      4'h8: pal = 12'h555;  4'h9: pal = 12'h55F;  4'hA: pal = 12'h5F5;  4'hB: pal = 12'h5FF;
      4'hC: pal = 12'hF55;  4'hD: pal = 12'hF5F;  4'hE: pal = 12'hFF5;  default: pal = 12'hFFF;
    endcase
  endfunction

  // Stage 0: cell lookup and cursor match straight off the scanner coordinates.
  assign col       = bus.HAddr[9:3];
  assign row       = bus.VAddr[8:4];
  assign bus.charAddr = 12'({row, 6'b0}) + 12'({row, 4'b0}) + 12'(col);
  assign in_range0 = (bus.HAddr < H_ACTIVE) && (bus.VAddr < V_ACTIVE);
  assign hit0      = cursor_q[12] && (col == cursor_q[6:0]) && (row == cursor_q[11:7])
                     && (bus.VAddr[3:0] >= 4'd14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xbit1     <= '0;
      grow1     <= '0;
      in_range1 <= 1'b0;
      hit1      <= 1'b0;
    end else begin
      xbit1     <= bus.HAddr[2:0];
      grow1     <= bus.VAddr[3:0];
      in_range1 <= in_range0;
      hit1      <= hit0;
    end
  end

  // Stage 1: character word is back from RAM; form the glyph-row address.
  assign bus.fontAddr = {bus.charData[7:0], grow1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fg2       <= '0;
      bg2       <= '0;
      xbit2     <= '0;
      in_range2 <= 1'b0;
      hit2      <= 1'b0;
    end else begin
      fg2       <= bus.charData[11:8];
      bg2       <= bus.charData[15:12];
      xbit2     <= xbit1;
      in_range2 <= in_range1;
      hit2      <= hit1;
    end
  end

  // Stage 2: glyph row is back from ROM; bit 7 is the leftmost pixel, hence ~xbit2.
  assign pix_bit     = bus.fontData[~xbit2] ^ (hit2 & blink_on);
  assign bus.videoIn = in_range2 ? pal(pix_bit ? fg2 : bg2) : 12'h000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_q <= '0;
    end else if (bus.cursorWe) begin
      cursor_q <= bus.cursorDin;
    end
  end

  assign bus.cursorReg = cursor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (bus.frameStart) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_text_renderer.sv
// Self-checking bench for vga_text_renderer: memory models, pixel model and a due-cycle scoreboard.
module tb_vga_text_renderer;
  localparam int BF = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_text_renderer_if bus();

  vga_text_renderer #(.COLS(80), .ROWS(30), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] tram [4096];
  logic [7:0]  font [4096];

  always @(posedge clk) begin
    bus.charData <= tram[bus.charAddr];
    bus.fontData <= font[bus.fontAddr];
  end

  logic [11:0] pal_tbl [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                                12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  typedef struct {
    int          due;
    logic [11:0] exp;
    logic [9:0]  h;
    logic [8:0]  v;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc_cnt = 0;

  logic [12:0] m_cur;
  logic        m_blink;
  int          m_bcnt;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
      check_eq($sformatf("pix h=%0d v=%0d due=%0d", sb[0].h, sb[0].v, sb[0].due),
               32'(bus.videoIn), 32'(sb[0].exp));
      void'(sb.pop_front());
    end
  end

  function automatic logic [11:0] model_pix(input logic [9:0] h, input logic [8:0] v);
    logic [6:0]  c;
    logic [4:0]  r;
    logic [15:0] w;
    logic [7:0]  g;
    logic        hit;
    logic        b;
    int          addr;
    if (h >= 10'd640 || v >= 9'd480) return 12'h000;
    c    = h[9:3];
    r    = v[8:4];
    addr = int'(r) * 80 + int'(c);
    w    = tram[addr];
    g    = font[{w[7:0], v[3:0]}];
    hit  = m_cur[12] && (c == m_cur[6:0]) && (r == m_cur[11:7]) && (v[3:0] >= 4'd14);
    b    = g[7 - int'(h[2:0])] ^ (hit && m_blink);
    return pal_tbl[b ? w[11:8] : w[15:12]];
  endfunction

  // One pixel clock: drive inputs, queue the expected pixel two cycles out, update the model.
  task automatic cyc(input logic [9:0] h, input logic [8:0] v, input logic fs = 1'b0,
                     input logic we = 1'b0, input logic [12:0] din = 13'd0, input logic rel = 1'b0);
    sb_t e;
    @(posedge clk);
    #1;
    if (rel) begin
      rst_n = 1'b1;
      sb.push_back('{cyc_cnt, 12'h000, h, v});
      sb.push_back('{cyc_cnt + 1, 12'h000, h, v});
    end
    bus.HAddr      = h;
    bus.VAddr      = v;
    bus.frameStart = fs;
    bus.cursorWe   = we;
    bus.cursorDin  = din;
    if (fs && rst_n) begin
      if (m_bcnt == BF - 1) begin
        m_bcnt  = 0;
        m_blink = ~m_blink;
      end else begin
        m_bcnt++;
      end
    end
    e.due = cyc_cnt + 2;
    e.exp = rst_n ? model_pix(h, v) : 12'h000;
    e.h   = h;
    e.v   = v;
    sb.push_back(e);
    if (we && rst_n) m_cur = din;
  endtask

  task automatic pulses(input int n);
    repeat (2) cyc(10'd700, 9'd500);
    repeat (n) cyc(10'd700, 9'd500, 1'b1);
  endtask

  task automatic probe_cursor();
    for (int h = 22; h < 34; h++) cyc(10'(h), 9'd47);
    repeat (2) cyc(10'd700, 9'd500);
  endtask

  task automatic hold_reset(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.HAddr      = 10'($urandom_range(0, 1023));
      bus.VAddr      = 9'($urandom_range(0, 511));
      bus.frameStart = 1'($urandom_range(0, 1));
      bus.cursorWe   = 1'($urandom_range(0, 1));
      bus.cursorDin  = 13'($urandom_range(0, 8191));
      #1;
      check_eq("reset videoIn", 32'(bus.videoIn), 32'h0);
      check_eq("reset cursorReg", 32'(bus.cursorReg), 32'h0);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async videoIn", 32'(bus.videoIn), 32'h0);
    check_eq("async cursorReg", 32'(bus.cursorReg), 32'h0);
    sb.delete();
    m_cur   = 13'd0;
    m_blink = 1'b1;
    m_bcnt  = 0;
  endtask

  localparam logic [12:0] CUR_ON  = {1'b1, 5'd2, 7'd3};
  localparam logic [12:0] CUR_OFF = {1'b0, 5'd2, 7'd3};
  localparam logic [12:0] CUR_OOR = {1'b1, 5'd31, 7'd100};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish within budget");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tram[i] = 16'($urandom);
      font[i] = 8'($urandom);
    end
    tram[0]       = 16'h1F41;
    font[12'h410] = 8'h18;
    for (int r = 0; r < 16; r++) font[r] = 8'h00;
    tram[163]     = 16'h0700;
    tram[2399]    = 16'h2C5A;
    m_cur   = 13'd0;
    m_blink = 1'b1;
    m_bcnt  = 0;
    bus.HAddr = '0; bus.VAddr = '0; bus.frameStart = 1'b0;
    bus.cursorWe = 1'b0; bus.cursorDin = '0;

    hold_reset(6);
    cyc(10'd0, 9'd0, 1'b0, 1'b0, 13'd0, 1'b1);

    // Glyph row 0 of 'A': 00A x3, FFF x2, 00A x3.
    for (int i = 0; i < 8; i++) begin
      cyc(10'(i), 9'd0);
      #1;
      check_eq("fontAddr glyph", 32'(bus.fontAddr), 32'h410);
    end

    // Bottom-right cell, then first out-of-range column and scanner wrap values.
    cyc(10'd639, 9'd479);
    #1;
    check_eq("charAddr corner", 32'(bus.charAddr), 32'd2399);
    cyc(10'd640, 9'd479);
    #1;
    check_eq("fontAddr row15", 32'(bus.fontAddr), 32'h5AF);
    cyc(10'd799, 9'd524);
    cyc(10'd0, 9'd524);
    cyc(10'd799, 9'd0);

    // Cursor at (3,2): underline rows 46-47 only.
    cyc(10'd700, 9'd500, 1'b0, 1'b1, CUR_ON);
    cyc(10'd700, 9'd500);
    #1;
    check_eq("cursorReg on", 32'(bus.cursorReg), 32'(CUR_ON));
    for (int v = 30; v < 49; v++)
      for (int h = 22; h < 34; h++) cyc(10'(h), 9'(v));
    cyc(10'd700, 9'd500, 1'b0, 1'b1, CUR_OFF);
    for (int v = 44; v < 48; v++)
      for (int h = 22; h < 34; h++) cyc(10'(h), 9'(v));

    // Out-of-range cursor position is stored verbatim and matches nothing.
    cyc(10'd700, 9'd500, 1'b0, 1'b1, CUR_OOR);
    cyc(10'd700, 9'd500);
    #1;
    check_eq("cursorReg oor", 32'(bus.cursorReg), 32'(CUR_OOR));
    for (int v = 478; v < 480; v++)
      for (int h = 630; h < 642; h++) cyc(10'(h), 9'(v));

    // Blink: on through pulse 29, off at 30, still off at 59, on again at 60.
    cyc(10'd700, 9'd500, 1'b0, 1'b1, CUR_ON);
    pulses(29); probe_cursor();
    pulses(1);  probe_cursor();
    pulses(29); probe_cursor();
    pulses(1);  probe_cursor();

    // Cursor write coincident with a cursor-cell pixel.
    cyc(10'd24, 9'd46, 1'b0, 1'b1, CUR_OFF);
    cyc(10'd25, 9'd46);
    cyc(10'd26, 9'd46, 1'b0, 1'b1, CUR_ON);
    cyc(10'd27, 9'd46);
    cyc(10'd28, 9'd46);

    // Mid-line asynchronous reset with blink state away from reset values.
    pulses(33);
    cyc(10'd3, 9'd0);
    cyc(10'd3, 9'd0);
    cyc(10'd3, 9'd0);
    #1;
    check_eq("pre-reset pixel", 32'(bus.videoIn), 32'hFFF);
    async_reset();
    hold_reset(3);
    cyc(10'd3, 9'd0, 1'b0, 1'b0, 13'd0, 1'b1);
    cyc(10'd4, 9'd0);
    cyc(10'd700, 9'd500, 1'b0, 1'b1, CUR_ON);
    probe_cursor();
    pulses(29); probe_cursor();
    pulses(1);  probe_cursor();

    repeat (4) cyc(10'd700, 9'd500);
    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
